// File: rtl/unidad_control_multiciclo_pkg.sv
// rtl/unidad_control_multiciclo_pkg.sv - shared opcode, ALUOP and state encodings
// Purpose: constants shared by the multi-cycle controller and the single-cycle decoder.
// Ports: none (package).
package unidad_control_multiciclo_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [2:0] ALU_FUNCT = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC_R = 4'd2,
    ST_EXEC_I = 4'd3,
    ST_ADDR   = 4'd4,
    ST_MEM_RD = 4'd5,
    ST_MEM_WR = 4'd6,
    ST_WB_R   = 4'd7,
    ST_WB_I   = 4'd8,
    ST_WB_MEM = 4'd9,
    ST_BRANCH = 4'd10
  } state_t;

endpackage

// File: rtl/unidad_control_multiciclo_contador_instr.sv
// rtl/unidad_control_multiciclo_contador_instr.sv - enabled wrap-around counter for retired instructions
// Purpose: CNT_W-bit up counter, increments when en is high, wraps to 0.
// Ports: clk, reset (sync, active-high), en (count enable), count (current value).
module contador_instr #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// rtl/unidad_control_multiciclo.sv - multi-cycle processor controller
// Purpose: sequences fetch/decode/execute/memory/write-back and drives datapath controls.
// Ports: clk, reset (sync, active-high); inst (IR opcode), mem_ready (memory handshake);
//        PCWrite, IRWrite, RegDst, Branch, MemRead, MemToRg, ALUOP, MemToWrite, ALUSrc,
//        RegWrite (datapath controls); retire, illegal (pulses); instret (retired count).
module unidad_control_multiciclo
  import unidad_control_multiciclo_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       inst,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             Branch,
  output logic             MemRead,
  output logic             MemToRg,
  output logic [2:0]       ALUOP,
  output logic             MemToWrite,
  output logic             ALUSrc,
  output logic             RegWrite,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t     state;
  state_t     state_next;
  logic [5:0] opcode_q;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_FETCH;
      opcode_q <= '0;
    end else begin
      state <= state_next;
      // Latch the opcode once; later IR changes cannot redirect ADDR.
      if (state == ST_DECODE) begin
        opcode_q <= inst;
      end
    end
  end

  always_comb begin
    state_next = state;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    Branch     = 1'b0;
    MemRead    = 1'b0;
    MemToRg    = 1'b0;
    ALUOP      = ALU_FUNCT;
    MemToWrite = 1'b0;
    ALUSrc     = 1'b0;
    RegWrite   = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;

    case (state)
      ST_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          PCWrite    = 1'b1;
          IRWrite    = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (inst)
          OP_RTYPE:     state_next = ST_EXEC_R;
          OP_ADDI:      state_next = ST_EXEC_I;
          OP_LW, OP_SW: state_next = ST_ADDR;
          OP_BEQ:       state_next = ST_BRANCH;
          default: begin
            illegal    = 1'b1;
            state_next = ST_FETCH;
          end
        endcase
      end
      ST_EXEC_R: begin
        ALUOP      = ALU_FUNCT;
        state_next = ST_WB_R;
      end
      ST_EXEC_I: begin
        ALUOP      = ALU_ADD;
        ALUSrc     = 1'b1;
        state_next = ST_WB_I;
      end
      ST_ADDR: begin
        ALUOP      = ALU_ADD;
        ALUSrc     = 1'b1;
        state_next = (opcode_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          state_next = ST_WB_MEM;
        end
      end
      ST_MEM_WR: begin
        MemToWrite = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_WB_R: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_WB_I: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_WB_MEM: begin
        MemToRg    = 1'b1;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_BRANCH: begin
        ALUOP      = ALU_SUB;
        Branch     = 1'b1;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase

    // Reset silences every control immediately, so an abandoned
    // instruction can neither write nor retire in the reset cycle.
    if (reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      Branch     = 1'b0;
      MemRead    = 1'b0;
      MemToRg    = 1'b0;
      ALUOP      = ALU_FUNCT;
      MemToWrite = 1'b0;
      ALUSrc     = 1'b0;
      RegWrite   = 1'b0;
      retire     = 1'b0;
      illegal    = 1'b0;
    end
  end

  contador_instr #(
    .CNT_W(CNT_W)
  ) u_contador_instr (
    .clk   (clk),
    .reset (reset),
    .en    (retire),
    .count (count)
  );

  assign instret = reset ? '0 : count;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// tb/tb_unidad_control_multiciclo.sv - scoreboard bench for the multi-cycle controller
module tb_unidad_control_multiciclo;

  localparam int CW = 4;

  localparam logic [5:0] R_OP   = 6'b000000;
  localparam logic [5:0] ADDI_OP = 6'b000010;
  localparam logic [5:0] LW_OP  = 6'b100011;
  localparam logic [5:0] SW_OP  = 6'b101011;
  localparam logic [5:0] BEQ_OP = 6'b000100;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    inst = '0;
  logic          mem_ready = 1'b0;
  logic          PCWrite, IRWrite, RegDst, Branch, MemRead, MemToRg;
  logic [2:0]    ALUOP;
  logic          MemToWrite, ALUSrc, RegWrite, retire, illegal;
  logic [CW-1:0] instret;

  unidad_control_multiciclo #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .inst(inst), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegDst(RegDst), .Branch(Branch),
    .MemRead(MemRead), .MemToRg(MemToRg), .ALUOP(ALUOP), .MemToWrite(MemToWrite),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .retire(retire), .illegal(illegal),
    .instret(instret)
  );

  always #5 clk = ~clk;

  // Per-instruction signature: how many cycles each control was high,
  // the control vector in the completing cycle and the counter around it.
  typedef struct {
    int cycles, n_memread, n_pcw, n_irw, n_memwr, n_regwr, n_alusrc;
    int n_add, n_sub, n_branch, n_regdst, n_memtorg, n_both;
    logic [11:0]   fin;
    logic          ill;
    logic [CW-1:0] ir_at;
    logic [CW-1:0] ir_next;
  } sig_t;

  sig_t expq[$];
  int checks = 0;
  int passes = 0;
  logic [CW-1:0] m_instret = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [11:0] vec(input logic pcw, irw, rdst, br, mrd, m2r,
                                      input logic [2:0] aop, input logic mwr, asrc, rwr);
    return {pcw, irw, rdst, br, mrd, m2r, aop, mwr, asrc, rwr};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op == R_OP || op == ADDI_OP || op == LW_OP || op == SW_OP || op == BEQ_OP;
  endfunction

  // Reference: cycle budgets and control usage straight from the ISA rules.
  function automatic sig_t expect_sig(input logic [5:0] op, input int wf, input int wm,
                                      input logic [CW-1:0] ir);
    sig_t s;
    s = '{default: 0};
    s.n_pcw = 1; s.n_irw = 1; s.n_memread = wf + 1;
    s.ir_at = ir; s.ir_next = ir + 1'b1;
    if (op == R_OP) begin
      s.cycles = 4 + wf; s.n_regwr = 1; s.n_regdst = 1;
      s.fin = vec(0, 0, 1, 0, 0, 0, 3'b000, 0, 0, 1);
    end else if (op == ADDI_OP) begin
      s.cycles = 4 + wf; s.n_regwr = 1; s.n_add = 1; s.n_alusrc = 1;
      s.fin = vec(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1);
    end else if (op == LW_OP) begin
      s.cycles = 5 + wf + wm; s.n_memread += wm + 1; s.n_memtorg = 1; s.n_regwr = 1;
      s.n_add = 1; s.n_alusrc = 1;
      s.fin = vec(0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 1);
    end else if (op == SW_OP) begin
      s.cycles = 4 + wf + wm; s.n_memwr = wm + 1; s.n_add = 1; s.n_alusrc = 1;
      s.fin = vec(0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0);
    end else if (op == BEQ_OP) begin
      s.cycles = 3 + wf; s.n_branch = 1; s.n_sub = 1;
      s.fin = vec(0, 0, 0, 1, 0, 0, 3'b010, 0, 0, 0);
    end else begin
      s.cycles = 2 + wf; s.ill = 1'b1; s.ir_next = ir;
      s.fin = vec(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    end
    return s;
  endfunction

  function automatic int mem_op(input logic [5:0] op);
    return (op == LW_OP || op == SW_OP) ? 1 : 0;
  endfunction

  // Drive one instruction: opcode only valid in the DECODE cycle, memory
  // stalls of wf cycles in FETCH and wm cycles in the data access.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    sig_t e;
    int ms;
    e = expect_sig(op, wf, wm, m_instret);
    expq.push_back(e);
    m_instret = e.ir_next;
    ms = wf + 3;
    for (int t = 0; t < e.cycles; t++) begin
      inst = (t == wf + 1) ? op : 6'($urandom);
      mem_ready = !((t < wf) || (mem_op(op) == 1 && t >= ms && t < ms + wm));
      @(posedge clk); #1;
    end
  endtask

  // SW stalled in its write phase, then reset: nothing may retire.
  task automatic abort_sw(input int wf);
    for (int t = 0; t < wf + 5; t++) begin
      inst = (t == wf + 1) ? SW_OP : 6'($urandom);
      mem_ready = !((t < wf) || t >= wf + 3);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    mem_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    m_instret = '0;
  endtask

  sig_t acc;
  logic pend = 1'b0;
  logic [CW-1:0] pend_val;

  initial acc = '{default: 0};

  always @(negedge clk) begin
    if (reset) begin
      chk("reset_outputs", {PCWrite, IRWrite, RegDst, Branch, MemRead, MemToRg, ALUOP,
                            MemToWrite, ALUSrc, RegWrite, retire, illegal, instret}, 0);
      acc = '{default: 0};
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("instret_after_pulse", instret, pend_val);
        pend = 1'b0;
      end
      acc.cycles++;
      acc.n_memread += int'(MemRead);
      acc.n_pcw     += int'(PCWrite);
      acc.n_irw     += int'(IRWrite);
      acc.n_memwr   += int'(MemToWrite);
      acc.n_regwr   += int'(RegWrite);
      acc.n_alusrc  += int'(ALUSrc);
      acc.n_add     += int'(ALUOP == 3'b001);
      acc.n_sub     += int'(ALUOP == 3'b010);
      acc.n_branch  += int'(Branch);
      acc.n_regdst  += int'(RegDst);
      acc.n_memtorg += int'(MemToRg);
      acc.n_both    += int'(RegWrite && MemToWrite);
      if (retire || illegal) begin
        acc.fin = {PCWrite, IRWrite, RegDst, Branch, MemRead, MemToRg, ALUOP,
                   MemToWrite, ALUSrc, RegWrite};
        acc.ir_at = instret;
        if (expq.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          sig_t e;
          e = expq.pop_front();
          chk("cycles", acc.cycles, e.cycles);
          chk("memread_cycles", acc.n_memread, e.n_memread);
          chk("pcwrite_cycles", acc.n_pcw, e.n_pcw);
          chk("irwrite_cycles", acc.n_irw, e.n_irw);
          chk("memtowrite_cycles", acc.n_memwr, e.n_memwr);
          chk("regwrite_cycles", acc.n_regwr, e.n_regwr);
          chk("alusrc_cycles", acc.n_alusrc, e.n_alusrc);
          chk("aluop_add_cycles", acc.n_add, e.n_add);
          chk("aluop_sub_cycles", acc.n_sub, e.n_sub);
          chk("branch_cycles", acc.n_branch, e.n_branch);
          chk("regdst_cycles", acc.n_regdst, e.n_regdst);
          chk("memtorg_cycles", acc.n_memtorg, e.n_memtorg);
          chk("regwrite_and_memwrite", acc.n_both, 0);
          chk("final_controls", acc.fin, e.fin);
          chk("illegal_pulse", illegal, e.ill);
          chk("retire_pulse", retire, !e.ill);
          chk("instret_at_pulse", acc.ir_at, e.ir_at);
          pend_val = e.ir_next;
          pend = 1'b1;
        end
        acc = '{default: 0};
      end
    end
  end

  initial begin
    logic [5:0] op;
    int sel;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    run_instr(R_OP, 0, 0);
    run_instr(LW_OP, 0, 2);
    run_instr(SW_OP, 0, 0);
    run_instr(BEQ_OP, 0, 0);
    run_instr(6'b111111, 0, 0);
    abort_sw(1);
    run_instr(ADDI_OP, 0, 0);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: op = R_OP;
        1: op = ADDI_OP;
        2: op = LW_OP;
        3: op = SW_OP;
        4: op = BEQ_OP;
        default: begin
          op = 6'($urandom);
          while (is_legal(op)) op = 6'($urandom);
        end
      endcase
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    mem_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("scoreboard_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
